// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: sequences the fetch/execute strobes for the CPU datapath
// from the latched instruction class. Every output is a register loaded from the next-state decode.
module control_sequencer #(
  parameter int OPC_MSB         = 31,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        stop,
  output logic        PCout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic [4:0]  state_dbg
);

  typedef enum logic [4:0] {
    S_RST   = 5'd0,
    S_T0    = 5'd1,
    S_T1    = 5'd2,
    S_T2    = 5'd3,
    S_T3    = 5'd4,
    S_T4    = 5'd5,
    S_T5    = 5'd6,
    S_T6    = 5'd7,
    S_T7    = 5'd8,
    S_PAUSE = 5'd9,
    S_HALT  = 5'd10
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_ADDI, C_NOP, C_HALT, C_ILL
  } iclass_t;

  typedef struct packed {
    logic pc_out, zlow_out, mdr_out, r_out, ba_out, c_out;
    logic mar_in, mdr_in, pc_in, ir_in, y_in, r_in, zhigh_in, zlow_in;
    logic inc_pc, read, write, gra, grb, grc, run;
  } ctrl_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  function automatic iclass_t classify(input logic [4:0] op);
    case (op)
      5'b00000: return C_LD;
      5'b00001: return C_LDI;
      5'b00010: return C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110: return C_ALU;
      5'b01100: return C_ADDI;
      5'b11000: return C_NOP;
      5'b11001: return C_HALT;
      default:  return HALT_ON_ILLEGAL ? C_ILL : C_NOP;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      5'b00100: return ALU_SUB;
      5'b00101: return ALU_AND;
      5'b00110: return ALU_OR;
      default:  return ALU_ADD;
    endcase
  endfunction

  // Strobe set for a state; only T3..T7 look at the latched instruction class.
  function automatic ctrl_t decode(input state_t s, input iclass_t c);
    ctrl_t o;
    logic  mem_op;
    o      = '0;
    mem_op = (c == C_LD) || (c == C_LDI) || (c == C_ST);
    o.run  = (s >= S_T0) && (s <= S_T7);
    case (s)
      S_T0: begin
        o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1;
        o.zhigh_in = 1'b1; o.zlow_in = 1'b1;
      end
      S_T1: begin
        o.zlow_out = 1'b1; o.pc_in = 1'b1; o.read = 1'b1; o.mdr_in = 1'b1;
      end
      S_T2: begin
        o.mdr_out = 1'b1; o.ir_in = 1'b1;
      end
      S_T3: begin
        if (mem_op) begin
          o.grb = 1'b1; o.ba_out = 1'b1; o.y_in = 1'b1;
        end else if (c == C_ALU || c == C_ADDI) begin
          o.grb = 1'b1; o.r_out = 1'b1; o.y_in = 1'b1;
        end
      end
      S_T4: begin
        o.zhigh_in = 1'b1; o.zlow_in = 1'b1;
        if (c == C_ALU) begin
          o.grc = 1'b1; o.r_out = 1'b1;
        end else begin
          o.c_out = 1'b1;
        end
      end
      S_T5: begin
        o.zlow_out = 1'b1;
        if (c == C_LD || c == C_ST) begin
          o.mar_in = 1'b1;
        end else begin
          o.gra = 1'b1; o.r_in = 1'b1;
        end
      end
      S_T6: begin
        o.mdr_in = 1'b1;
        if (c == C_ST) begin
          o.gra = 1'b1; o.r_out = 1'b1;
        end else begin
          o.read = 1'b1;
        end
      end
      S_T7: begin
        o.mdr_out = 1'b1;
        if (c == C_ST) begin
          o.write = 1'b1;
        end else begin
          o.gra = 1'b1; o.r_in = 1'b1;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t      state, state_nx, boundary;
  iclass_t     cls, cls_nx;
  ctrl_t       ctrl;
  logic [4:0]  opcode;
  logic        unused_ir;

  assign opcode    = ir[OPC_MSB -: 5];
  assign unused_ir = ^ir;

  // NOTE: every variable in this block is assigned before any branch so no latch is inferred.
  always_comb begin
    cls_nx   = (state == S_T2) ? classify(opcode) : cls;
    boundary = stop ? S_PAUSE : S_T0;
    state_nx = state;
    case (state)
      S_RST:   state_nx = stop ? S_RST : S_T0;
      S_T0:    state_nx = S_T1;
      S_T1:    state_nx = S_T2;
      S_T2:    state_nx = S_T3;
      S_T3: begin
        case (cls)
          C_NOP:         state_nx = boundary;
          C_HALT, C_ILL: state_nx = S_HALT;
          default:       state_nx = S_T4;
        endcase
      end
      S_T4:    state_nx = S_T5;
      S_T5:    state_nx = (cls == C_LD || cls == C_ST) ? S_T6 : boundary;
      S_T6:    state_nx = S_T7;
      S_T7:    state_nx = boundary;
      S_PAUSE: state_nx = stop ? S_PAUSE : S_T0;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_RST;
      cls     <= C_NOP;
      ctrl    <= '0;
      alu_op  <= ALU_ADD;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      cls   <= cls_nx;
      ctrl  <= decode(state_nx, cls_nx);
      if (state == S_T2) alu_op <= alu_code(opcode);
      if (state == S_T3 && cls == C_ILL) illegal <= 1'b1;
    end
  end

  assign PCout     = ctrl.pc_out;
  assign ZLowout   = ctrl.zlow_out;
  assign MDRout    = ctrl.mdr_out;
  assign Rout      = ctrl.r_out;
  assign BAout     = ctrl.ba_out;
  assign Cout      = ctrl.c_out;
  assign MARin     = ctrl.mar_in;
  assign MDRin     = ctrl.mdr_in;
  assign PCin      = ctrl.pc_in;
  assign IRin      = ctrl.ir_in;
  assign Yin       = ctrl.y_in;
  assign Rin       = ctrl.r_in;
  assign ZHighIn   = ctrl.zhigh_in;
  assign ZLowIn    = ctrl.zlow_in;
  assign IncPC     = ctrl.inc_pc;
  assign Read      = ctrl.read;
  assign Write     = ctrl.write;
  assign Gra       = ctrl.gra;
  assign Grb       = ctrl.grb;
  assign Grc       = ctrl.grc;
  assign run       = ctrl.run;
  assign state_dbg = state;

endmodule
